// File: rtl/srt_div_pkg.sv
// Shared definitions for the radix-2 SRT divider: signed quotient-digit
// encoding and the on-the-fly conversion FSM states.
package srt_div_pkg;

    localparam logic [1:0] DIG_POS  = 2'b10;
    localparam logic [1:0] DIG_ZERO = 2'b00;
    localparam logic [1:0] DIG_NEG  = 2'b01;
    localparam logic [1:0] DIG_ILL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CONV = 2'b01,
        ST_CORR = 2'b10,
        ST_DONE = 2'b11
    } otfc_state_t;

endpackage

// File: rtl/radix_2_srt_otfc_step.sv
// One on-the-fly conversion step: appends a signed digit to Q / QM.
// Purely combinational so two instances can be chained for radix-4.
module radix_2_srt_otfc_step
    import srt_div_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] qm_i,
    input  logic [1:0]       dig_i,
    output logic [WIDTH-1:0] q_nxt_o,
    output logic [WIDTH-1:0] qm_nxt_o
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    // Select shift source per digit; illegal encoding behaves like zero.
    always_comb begin
        q_nxt_o  = q_i << 1;
        qm_nxt_o = (qm_i << 1) | ONE;
        case (dig_i)
            DIG_POS: begin
                q_nxt_o  = (q_i << 1) | ONE;
                qm_nxt_o = q_i << 1;
            end
            DIG_NEG: begin
                q_nxt_o  = (qm_i << 1) | ONE;
                qm_nxt_o = qm_i << 1;
            end
            DIG_ZERO: begin
                q_nxt_o  = q_i << 1;
                qm_nxt_o = (qm_i << 1) | ONE;
            end
            default: begin
                q_nxt_o  = q_i << 1;
                qm_nxt_o = (qm_i << 1) | ONE;
            end
        endcase
    end

endmodule

// File: rtl/radix_2_srt_otfc.sv
// On-the-fly quotient conversion for the radix-2 SRT divider: keeps Q and
// Q-1 so the final remainder-sign correction is a simple select.
module radix_2_srt_otfc
    import srt_div_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_valid_i,
    output logic             start_ready_o,
    input  logic [CNT_W-1:0] num_dig_i,
    input  logic             dig_valid_i,
    output logic             dig_ready_o,
    input  logic [1:0]       dig_i,
    input  logic             rem_sign_valid_i,
    output logic             rem_sign_ready_o,
    input  logic             rem_neg_i,
    input  logic             flush_i,
    output logic             fin_valid_o,
    input  logic             fin_ready_i,
    output logic [WIDTH-1:0] quot_o,
    output logic             err_o
);

    otfc_state_t      state_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] qm_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] num_dig_r;
    logic [CNT_W-1:0] cnt_inc_s;
    logic [WIDTH-1:0] q_nxt_s;
    logic [WIDTH-1:0] qm_nxt_s;

    radix_2_srt_otfc_step #(.WIDTH(WIDTH)) u_step (
        .q_i      (q_r),
        .qm_i     (qm_r),
        .dig_i    (dig_i),
        .q_nxt_o  (q_nxt_s),
        .qm_nxt_o (qm_nxt_s)
    );

    assign cnt_inc_s        = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    assign start_ready_o    = (state_r == ST_IDLE);
    assign dig_ready_o      = (state_r == ST_CONV);
    assign rem_sign_ready_o = (state_r == ST_CORR);

    // Conversion FSM with registered result, error flag and valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            q_r         <= {WIDTH{1'b0}};
            qm_r        <= {WIDTH{1'b1}};
            cnt_r       <= {CNT_W{1'b0}};
            num_dig_r   <= {CNT_W{1'b0}};
            quot_o      <= {WIDTH{1'b0}};
            fin_valid_o <= 1'b0;
            err_o       <= 1'b0;
        end else if (flush_i) begin
            // Abort keeps datapath contents; only control returns to idle.
            state_r     <= ST_IDLE;
            fin_valid_o <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start_valid_i) begin
                        num_dig_r <= num_dig_i;
                        q_r       <= {WIDTH{1'b0}};
                        qm_r      <= {WIDTH{1'b1}};
                        cnt_r     <= {CNT_W{1'b0}};
                        err_o     <= 1'b0;
                        state_r   <= (num_dig_i == {CNT_W{1'b0}}) ? ST_CORR : ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (dig_valid_i) begin
                        q_r   <= q_nxt_s;
                        qm_r  <= qm_nxt_s;
                        cnt_r <= cnt_inc_s;
                        if (dig_i == DIG_ILL) begin
                            err_o <= 1'b1;
                        end
                        if (cnt_inc_s == num_dig_r) begin
                            state_r <= ST_CORR;
                        end
                    end
                end
                ST_CORR: begin
                    if (rem_sign_valid_i) begin
                        quot_o      <= rem_neg_i ? qm_r : q_r;
                        fin_valid_o <= 1'b1;
                        state_r     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (fin_ready_i) begin
                        fin_valid_o <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    fin_valid_o <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
